// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, funct codes and sequencer state type for alu_md_ctrl
// Contents:
//   ALU_*      4-bit ALU opcodes driven on alu_ctrl
//   ALU_OP_*   2-bit alu_op classes from main control
//   F7_MULDIV  funct7 value that selects the RV32M group
//   F3_*       RV32M funct3 codes
//   md_state_t multiply/divide sequencer states
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MD   = 4'b1111;

    localparam logic [1:0] ALU_OP_LDST   = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } md_state_t;

endpackage

// File: rtl/md_iter_datapath.sv
// rtl/md_iter_datapath.sv - shared shift-add multiplier / restoring divider iteration registers
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears all registers)
//   load            capture magnitudes: lo <= a_in, operand <= b_in, hi <= 0
//   step            advance one iteration (hi/lo <= hi_nxt/lo_nxt)
//   is_div          select divider step (1) or multiplier step (0)
//   a_in, b_in      unsigned operand magnitudes
//   hi_nxt, lo_nxt  value hi/lo take after the current step (product {hi,lo} or remainder/quotient)
module md_iter_datapath #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    // Multiply: {hi,lo} is the product register, lo starts as the multiplier and
    // is consumed MUL_BPC bits per step from the bottom. Divide: hi is the partial
    // remainder, lo starts as the dividend and fills with quotient bits.
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opnd_q;

    logic [XLEN+MUL_BPC-1:0] partial;
    logic [XLEN+MUL_BPC-1:0] msum;
    logic [XLEN:0]           rshift;
    logic [XLEN-1:0]         rdiff;
    logic                    fits;

    always_comb begin
        partial = {{XLEN{1'b0}}, lo_q[MUL_BPC-1:0]} * {{MUL_BPC{1'b0}}, opnd_q};
        msum    = {{MUL_BPC{1'b0}}, hi_q} + partial;

        // rshift < 2*divisor, so the difference always fits in XLEN bits when taken.
        rshift  = {hi_q, lo_q[XLEN-1]};
        fits    = (rshift >= {1'b0, opnd_q});
        rdiff   = rshift[XLEN-1:0] - opnd_q;

        if (is_div) begin
            hi_nxt = fits ? rdiff : rshift[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], fits};
        end else begin
            {hi_nxt, lo_nxt} = {msum, lo_q[XLEN-1:MUL_BPC]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (load) begin
            hi_q   <= '0;
            lo_q   <= a_in;
            opnd_q <= b_in;
        end else if (step) begin
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
        end
    end

endmodule

// File: rtl/alu_md_ctrl.sv
// rtl/alu_md_ctrl.sv - EX-stage ALU decode plus iterative RV32M multiply/divide sequencer
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   alu_op            main-control class: 00 ld/st, 01 branch, 10 R-type, 11 I-type
//   funct7, funct3    instruction function fields
//   in_valid          EX holds a live instruction
//   flush             EX instruction killed this cycle
//   op_a, op_b        rs1/rs2 values after forwarding
//   alu_ctrl          combinational ALU opcode (1111 for M ops)
//   use_md            combinational: instruction is an RV32M op
//   stall             combinational: hold IF/ID/EX, bubble MEM
//   md_done           registered: md_result valid this cycle
//   md_result         registered M-op result, held until the next completion
// MUL_BPC must divide XLEN (1, 2 or 4).
module alu_md_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_ctrl,
    output logic            use_md,
    output logic            stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    localparam int              CW    = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   MUL_N = CW'(XLEN / MUL_BPC);
    localparam logic [CW-1:0]   DIV_N = CW'(XLEN);
    localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};

    // ---------------------------------------------------------------- decode
    assign use_md = (alu_op == ALU_OP_RTYPE) && (funct7 == F7_MULDIV);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALU_OP_LDST: alu_ctrl = ALU_ADD;
            ALU_OP_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   alu_ctrl = ALU_SUB;
                    2'b10:   alu_ctrl = ALU_SLT;
                    2'b11:   alu_ctrl = ALU_SLTU;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: begin
                if (use_md) begin
                    alu_ctrl = ALU_MD;
                end else begin
                    case (funct3)
                        // funct7[5] only turns add into sub for register-register ops;
                        // addi has an immediate in those bits.
                        3'b000:  alu_ctrl = (alu_op == ALU_OP_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  alu_ctrl = ALU_SLL;
                        3'b010:  alu_ctrl = ALU_SLT;
                        3'b011:  alu_ctrl = ALU_SLTU;
                        3'b100:  alu_ctrl = ALU_XOR;
                        3'b101:  alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  alu_ctrl = ALU_OR;
                        default: alu_ctrl = ALU_AND;
                    endcase
                end
            end
        endcase
    end

    // ------------------------------------------------------- operand capture
    logic            go;
    logic            a_signed;
    logic            b_signed;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            fast;
    logic [XLEN-1:0] fast_result;

    assign go    = in_valid & use_md & ~flush;

    always_comb begin
        a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
        b_signed = a_signed && (funct3 != F3_MULHSU);
        sa       = a_signed & op_a[XLEN-1];
        sb       = b_signed & op_b[XLEN-1];
        a_mag    = sa ? -op_a : op_a;
        b_mag    = sb ? -op_b : op_b;

        // Divide corner cases resolve in the start cycle without iterating.
        div_zero = (op_b == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (op_a == XMIN) && (op_b == '1);
        fast     = funct3[2] & (div_zero | div_ovf);
        if (div_zero) begin
            fast_result = funct3[1] ? op_a : '1;
        end else begin
            fast_result = funct3[1] ? '0 : XMIN;
        end
    end

    // ------------------------------------------------------------------- FSM
    md_state_t     state_q;
    md_state_t     state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    f3_q;
    logic          sa_q;
    logic          sb_q;
    logic          start;
    logic          step;
    logic          last;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (go) begin
                    start = 1'b1;
                    if (!funct3[2]) begin
                        state_d = MD_MUL;
                    end else begin
                        state_d = fast ? MD_DONE : MD_DIV;
                    end
                end
            end
            MD_MUL, MD_DIV: begin
                // in_valid is deliberately not consulted: once started, only flush aborts.
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CW'(1)) begin
                        last    = 1'b1;
                        state_d = MD_DONE;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign stall = go & (state_q != MD_DONE);

    // -------------------------------------------------------------- datapath
    logic [XLEN-1:0]   hi_nxt;
    logic [XLEN-1:0]   lo_nxt;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   slow_result;

    md_iter_datapath #(
        .XLEN    (XLEN),
        .MUL_BPC (MUL_BPC)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start),
        .step   (step),
        .is_div (state_q == MD_DIV),
        .a_in   (a_mag),
        .b_in   (b_mag),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // The datapath works on magnitudes; the sign is reapplied to the final step's
    // value so the result can be registered on the same edge as the last iteration.
    always_comb begin
        prod        = {hi_nxt, lo_nxt};
        prod_fix    = (sa_q ^ sb_q) ? -prod : prod;
        quo_fix     = (sa_q ^ sb_q) ? -lo_nxt : lo_nxt;
        rem_fix     = sa_q ? -hi_nxt : hi_nxt;
        slow_result = rem_fix;
        case (f3_q)
            F3_MUL:                       slow_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: slow_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              slow_result = quo_fix;
            F3_REM, F3_REMU:              slow_result = rem_fix;
            default:                      slow_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            md_done   <= 1'b0;
            md_result <= '0;
        end else begin
            state_q <= state_d;
            md_done <= (state_d == MD_DONE);
            if (start) begin
                f3_q  <= funct3;
                sa_q  <= sa;
                sb_q  <= sb;
                cnt_q <= funct3[2] ? DIV_N : MUL_N;
                if (fast) begin
                    md_result <= fast_result;
                end
            end
            if (step) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (last) begin
                md_result <= slow_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_md_ctrl.sv
// tb/tb_alu_md_ctrl.sv - self-checking bench for alu_md_ctrl (MUL_BPC=1 and MUL_BPC=4 instances)
module tb_alu_md_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [1:0]  iv;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic [3:0]  ctrl_v [2];
    logic [1:0]  use_v;
    logic [1:0]  stall_v;
    logic [1:0]  done_v;
    logic [31:0] res_v [2];

    always #5 clk = ~clk;

    alu_md_ctrl #(.XLEN(32), .MUL_BPC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
        .in_valid(iv[0]), .flush(flush), .op_a(op_a), .op_b(op_b),
        .alu_ctrl(ctrl_v[0]), .use_md(use_v[0]), .stall(stall_v[0]),
        .md_done(done_v[0]), .md_result(res_v[0])
    );

    alu_md_ctrl #(.XLEN(32), .MUL_BPC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
        .in_valid(iv[1]), .flush(flush), .op_a(op_a), .op_b(op_b),
        .alu_ctrl(ctrl_v[1]), .use_md(use_v[1]), .stall(stall_v[1]),
        .md_done(done_v[1]), .md_result(res_v[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state shared between the stimulus and the compare process.
    logic        chk_on = 1'b0;
    logic        op_act = 1'b0;
    logic        aborted = 1'b0;
    int          sel = 0;
    int          k = 0;
    int          lat = 0;
    logic [31:0] cur_ref = '0;
    logic [31:0] res_hold [2] = '{32'h0, 32'h0};

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] at t=%0t: got %h expected %h", nm, idx, $time, act, exp);
        end
    endtask

    // Decode written as the mnemonic table from the ISA.
    function automatic logic [3:0] dec_ref(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        logic alt;
        alt = (f7 == 7'b0100000) || f7[5];
        case (op)
            2'd0: return 4'b0010;
            2'd1: begin
                if (f3 == 3'd0 || f3 == 3'd1) return 4'b0110;
                if (f3 == 3'd4 || f3 == 3'd5) return 4'b1000;
                if (f3 == 3'd6 || f3 == 3'd7) return 4'b0111;
                return 4'b0010;
            end
            default: begin
                if (op == 2'd2 && f7 == 7'd1) return 4'b1111;
                case (f3)
                    3'd0: return (op == 2'd2 && alt) ? 4'b0110 : 4'b0010;
                    3'd1: return 4'b0100;
                    3'd2: return 4'b1000;
                    3'd3: return 4'b0111;
                    3'd4: return 4'b0011;
                    3'd5: return alt ? 4'b1001 : 4'b0101;
                    3'd6: return 4'b0001;
                    default: return 4'b0000;
                endcase
            end
        endcase
    endfunction

    // RV32M results from wide integer arithmetic.
    function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64, sb64, ub64, p;
        logic [63:0]        up;
        logic signed [31:0] sa32, sb32, t;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'h0, b};
        sa32 = a;
        sb32 = b;
        case (f3)
            3'd0: begin p = sa64 * sb64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                t = sa32 / sb32; return t;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                t = sa32 % sb32; return t;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from start to md_done.
    function automatic int lat_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int bpc);
        if (f3[2]) begin
            if (b == 0) return 1;
            if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return 33;
        end
        return 32 / bpc + 1;
    endfunction

    logic cmp_live;
    logic cmp_done;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                cmp_live = iv[d] && alu_op == 2'b10 && funct7 == 7'h01 && !flush;
                cmp_done = op_act && !aborted && sel == d && k == lat;
                chk("alu_ctrl", d, 32'(ctrl_v[d]), 32'(dec_ref(alu_op, funct7, funct3)));
                chk("use_md", d, 32'(use_v[d]), 32'(alu_op == 2'b10 && funct7 == 7'h01));
                chk("stall", d, 32'(stall_v[d]), 32'(cmp_live && !cmp_done));
                chk("md_done", d, 32'(done_v[d]), 32'(cmp_done));
                chk("md_result", d, res_v[d], cmp_done ? cur_ref : res_hold[d]);
            end
        end
    end

    task automatic idle(input int n);
        iv = '0; op_act = 1'b0; flush = 1'b0; alu_op = 2'b00; funct7 = '0; funct3 = '0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Issue one M op on dut d; optionally flush or reset at a given cycle offset.
    task automatic do_op(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int flush_k, input int rst_k, input logic [31:0] lit_res, input int lit_lat);
        logic stop;
        sel = d;
        cur_ref = md_ref(f3, a, b);
        lat = lat_ref(f3, a, b, (d == 1) ? 4 : 1);
        aborted = 1'b0;
        op_act = 1'b1;
        alu_op = 2'b10; funct7 = 7'h01; funct3 = f3; op_a = a; op_b = b;
        iv = '0; iv[d] = 1'b1;
        stop = 1'b0;
        for (int i = 0; i <= lat && !stop; i++) begin
            k = i;
            flush = (i == flush_k);
            rst_n = !(i == rst_k);
            if (i == lit_lat) begin
                #1;
                chk("lit_done", d, 32'(done_v[d]), 32'd1);
                chk("lit_result", d, res_v[d], lit_res);
            end
            @(posedge clk); #1;
            if (i == flush_k || i == rst_k) begin
                stop = 1'b1; aborted = 1'b1; flush = 1'b0; iv = '0;
                if (i == rst_k) begin
                    rst_n = 1'b1; res_hold[0] = '0; res_hold[1] = '0;
                end
            end
        end
        if (!stop) res_hold[d] = cur_ref;
        op_act = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; iv = '0; flush = 1'b0; alu_op = '0; funct7 = '0; funct3 = '0;
        op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Decode sweep over every class, funct3 and the three funct7 flavours.
        for (int o = 0; o < 4; o++) begin
            for (int f = 0; f < 8; f++) begin
                for (int s = 0; s < 3; s++) begin
                    alu_op = 2'(o); funct3 = 3'(f);
                    funct7 = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : 7'h01;
                    @(posedge clk); #1;
                end
            end
        end

        alu_op = 2'b10; funct7 = 7'b0100000; funct3 = 3'b000; #1;
        chk("dec_sub", 0, 32'(ctrl_v[0]), 32'h6);
        @(posedge clk); #1;
        alu_op = 2'b11; funct7 = 7'b0100000; funct3 = 3'b101; #1;
        chk("dec_srai", 0, 32'(ctrl_v[0]), 32'h9);
        @(posedge clk); #1;
        alu_op = 2'b01; funct7 = 7'b0000000; funct3 = 3'b111; #1;
        chk("dec_bgeu", 0, 32'(ctrl_v[0]), 32'h7);
        @(posedge clk); #1;
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000; #1;
        chk("dec_mop", 0, 32'(ctrl_v[0]), 32'hF);
        chk("dec_use_md", 0, 32'(use_v[0]), 32'h1);
        @(posedge clk); #1;
        idle(2);

        do_op(0, 3'd0, 32'd7, 32'hFFFFFFFD, -1, -1, 32'hFFFFFFEB, 33); idle(1);
        do_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, 32'hFFFFFFFE, 33); idle(1);
        do_op(0, 3'd4, 32'hFFFFFFF9, 32'd2, -1, -1, 32'hFFFFFFFD, 33); idle(1);
        do_op(0, 3'd6, 32'hFFFFFFF9, 32'd2, -1, -1, 32'hFFFFFFFF, 33); idle(1);
        do_op(0, 3'd5, 32'd100, 32'd7, -1, -1, 32'd14, 33); idle(1);
        do_op(0, 3'd7, 32'd100, 32'd7, -1, -1, 32'd2, 33); idle(1);
        do_op(0, 3'd5, 32'd5, 32'd0, -1, -1, 32'hFFFFFFFF, 1); idle(1);
        do_op(0, 3'd6, 32'd5, 32'd0, -1, -1, 32'd5, 1); idle(1);
        do_op(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, -1, -1, 32'h80000000, 1); idle(1);
        do_op(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, -1, -1, 32'h0, 1); idle(1);
        do_op(0, 3'd1, 32'h80000000, 32'h80000000, -1, -1, 32'h40000000, 33); idle(1);
        do_op(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, 32'hFFFFFFFF, 33); idle(1);

        // Flush mid-multiply, then a normal op proves the sequencer is idle again.
        do_op(0, 3'd0, 32'd123, 32'd456, 10, -1, 32'h0, -1); idle(3);
        do_op(0, 3'd4, 32'd1000, 32'hFFFFFFF9, -1, -1, 32'hFFFFFF72, 33); idle(1);

        // Back-to-back multiplies.
        do_op(0, 3'd0, 32'd12345, 32'd6789, -1, -1, 32'h0, -1);
        do_op(0, 3'd0, 32'hFFFF0000, 32'h00010001, -1, -1, 32'h0, -1); idle(1);

        // Four bits per cycle instance.
        do_op(1, 3'd0, 32'd7, 32'hFFFFFFFD, -1, -1, 32'hFFFFFFEB, 9);
        do_op(1, 3'd1, 32'h12345678, 32'h9ABCDEF0, -1, -1, 32'h0, -1); idle(1);
        do_op(1, 3'd6, 32'hFFFFFF00, 32'd7, -1, -1, 32'h0, -1); idle(1);

        // Reset in the middle of a multiply clears both instances.
        do_op(0, 3'd0, 32'd5, 32'd6, -1, 5, 32'h0, -1);
        chk("rst_result", 0, res_v[0], 32'h0);
        chk("rst_done", 0, 32'(done_v[0]), 32'h0);
        idle(2);
        do_op(0, 3'd2, 32'h80000000, 32'h00000003, -1, -1, 32'h0, -1); idle(2);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
